cache_line_arbiter_adapter: RTL and testbench
=============================================

Name: cache_line_arbiter_adapter

Overview:
Parametrised successor to the single-port cache/DRAM line adapter. Arbitrates NUM_CH cache line requesters (e.g. I-cache, D-cache, prefetcher) onto one burst DRAM port using round-robin. Serialises line writebacks into BEAT_WIDTH beats and assembles read bursts into full lines. Read beats are checked against the issued address rather than assumed in order. Sits between the cache bank(s) and the banked DRAM model / memory controller.

Parameters:
NUM_CH, 2, number of cache requesters (1..4)
ADDR_WIDTH, 32, byte address width
LINE_WIDTH, 256, cache line width in bits
BEAT_WIDTH, 64, DRAM data beat width; LINE_WIDTH must be a multiple of it; BEATS = LINE_WIDTH/BEAT_WIDTH (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ch_addr  in  NUM_CH*ADDR_WIDTH  per-channel line address, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
ch_wdata  in  NUM_CH*LINE_WIDTH  per-channel writeback line
ch_read  in  NUM_CH  per-channel line read request (level, held until ch_resp)
ch_write  in  NUM_CH  per-channel line write request (level, held until ch_resp)
ch_resp  out  NUM_CH  one-cycle completion pulse to the granted channel
ch_rdata  out  NUM_CH*LINE_WIDTH  per-channel read line, valid on ch_resp, held until that channel's next read completes
dram_addr  out  ADDR_WIDTH  line-aligned burst address
dram_read  out  1  one-cycle read command
dram_write  out  1  write beat valid
dram_wdata  out  BEAT_WIDTH  write beat data
dram_ready  in  1  DRAM accepts command/beat this cycle
dram_raddr  in  ADDR_WIDTH  line address of the returning read beat
dram_rdata  in  BEAT_WIDTH  read beat data
dram_rvalid  in  1  read beat valid
err_raddr  out  1  sticky: a read beat arrived with a mismatched address

Behaviour:
- Reset: state IDLE; ch_resp=0, ch_rdata=0, dram_read=0, dram_write=0, dram_wdata=0, dram_addr=0, err_raddr=0, beat counter=0, RR pointer=NUM_CH-1 (channel 0 wins first).
- States: IDLE, RD_CMD, RD_DATA, WR_DATA, RESP.
- IDLE: a channel is eligible if ch_read|ch_write. Grant goes to the first eligible channel searching upward from (RR pointer+1) mod NUM_CH. On grant: latch channel id, line-aligned addr (low log2(LINE_WIDTH/8) bits cleared), and wdata. Update RR pointer to the granted channel.
- Grant destination: if the granted channel has both read and write high, the write goes first (→WR_DATA); the read is then re-arbitrated later. Otherwise read→RD_CMD, write→WR_DATA.
- RD_CMD: dram_read=1 and dram_addr=latched addr. When dram_ready=1, move to RD_DATA; the command is counted exactly once. If dram_ready=0, hold dram_read high.
- RD_DATA: a beat is accepted only when dram_rvalid=1 and dram_raddr equals the latched addr. The beat is stored at slot [count*BEAT_WIDTH +: BEAT_WIDTH] and count increments. A beat with rvalid=1 and mismatched raddr is dropped and sets err_raddr (cleared only by rst). After beat BEATS-1 is accepted, the assembled line is written into that channel's ch_rdata slot and the block moves to RESP.
- WR_DATA: dram_write=1, dram_addr=latched addr, dram_wdata=latched line slot[count]. count increments only when dram_ready=1, and dram_wdata stays stable while dram_ready=0. After beat BEATS-1 is accepted (ready=1), dram_write drops to 0 the next cycle and the block moves to RESP.
- RESP: ch_resp[granted]=1 for exactly one cycle, then IDLE with count=0. No new grant happens in RESP, so the minimum gap between transactions is one IDLE cycle.
- Latency: a read with dram_ready=1 and back-to-back beats gives ch_resp 1(grant)+1(cmd)+BEATS+1 cycles after request. A write with ready=1 gives 1+BEATS+1.
- Requester dropping its request mid-transaction does not abort the transaction; the transaction still completes and pulses resp.
- Requests from non-granted channels are ignored until IDLE; no starvation (RR).
- Only one outstanding DRAM transaction exists at a time.
- rst mid-transaction returns everything to reset values the next cycle; partial beats are discarded.
- count is $clog2(BEATS) bits and wraps to 0 on completion.

Test Plan:
- Single read, ch0 addr 0x0000_1234: expect dram_read pulse with dram_addr=0x0000_1220. Return beats 0x11..,0x22..,0x33..,0x44.. with matching raddr. Expect ch_resp[0] one cycle with ch_rdata[0] = {0x44..,0x33..,0x22..,0x11..}, and resp 7 cycles after request.
- Write, ch1 wdata {D3,D2,D1,D0}, dram_ready low on the 2nd beat for 2 cycles: dram_wdata sequence D0,D1(held 3 cycles),D2,D3, then ch_resp[1] pulse; ch_rdata unchanged.
- Both channels request reads continuously for 3 transactions: grants are 0,1,0 and each resp goes only to its channel.
- Read beat with raddr 0x2000 while 0x1220 is pending: beat dropped, err_raddr=1 sticky. The later 4 matching beats complete the line correctly.
- ch0 asserts read and write together: write completes first (resp), then read is granted on the next arbitration.
- rst asserted after 2 read beats: all outputs are 0 next cycle. A new read afterwards completes normally with count starting at 0.

Source files
------------

// File: rtl/cache_line_arbiter_adapter.sv
`default_nettype none
// ============================================================================
//  Module   : cache_line_arbiter_adapter
//  Purpose  : Round-robin arbiter that connects NUM_CH cache line requesters
//             to a single burst DRAM port. Line writebacks are split into
//             BEAT_WIDTH beats. Read beats are checked against the issued
//             line address and then assembled into full lines.
//  Ports    :
//    clk, rst             clock, synchronous active-high reset
//    ch_addr/ch_wdata     packed per-channel line address / writeback line
//    ch_read/ch_write     per-channel level requests, held until ch_resp
//    ch_resp              one-cycle completion pulse to the granted channel
//    ch_rdata             packed per-channel read line, held until next read
//    dram_addr/read       line-aligned burst address, one-cycle read command
//    dram_write/wdata     write beat valid / data
//    dram_ready           DRAM accepts the command or beat this cycle
//    dram_raddr/rdata/    returning read beat: line address, data, valid
//    dram_rvalid
//    err_raddr            sticky flag, set by a read beat with a wrong address
//  Revision : 1.0  initial release
// ============================================================================
module cache_line_arbiter_adapter #(
   parameter int NUM_CH     = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256,
   parameter int BEAT_WIDTH = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
   input  logic [NUM_CH*LINE_WIDTH-1:0] ch_wdata,
   input  logic [NUM_CH-1:0]            ch_read,
   input  logic [NUM_CH-1:0]            ch_write,
   output logic [NUM_CH-1:0]            ch_resp,
   output logic [NUM_CH*LINE_WIDTH-1:0] ch_rdata,
   output logic [ADDR_WIDTH-1:0]        dram_addr,
   output logic                         dram_read,
   output logic                         dram_write,
   output logic [BEAT_WIDTH-1:0]        dram_wdata,
   input  logic                         dram_ready,
   input  logic [ADDR_WIDTH-1:0]        dram_raddr,
   input  logic [BEAT_WIDTH-1:0]        dram_rdata,
   input  logic                         dram_rvalid,
   output logic                         err_raddr
);

   localparam int BEATS    = LINE_WIDTH / BEAT_WIDTH;
   localparam int CNT_W    = $clog2(BEATS);
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int OFF_BITS = $clog2(LINE_WIDTH / 8);

   // Clears the byte-within-line bits of a request address.
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
      {{(ADDR_WIDTH-OFF_BITS){1'b1}}, {OFF_BITS{1'b0}}};
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
   // The pointer starts on the last channel so channel 0 wins the first grant.
   localparam logic [CH_W-1:0]  RR_INIT   = CH_W'(NUM_CH - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_CMD  = 3'd1,
      ST_RD_DATA = 3'd2,
      ST_WR_DATA = 3'd3,
      ST_RESP    = 3'd4
   } state_t;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t                  state_q,      state_d;
   logic [CH_W-1:0]         ch_q,         ch_d;
   logic [CH_W-1:0]         rr_q,         rr_d;
   logic [ADDR_WIDTH-1:0]   addr_q,       addr_d;
   logic [CNT_W-1:0]        cnt_q,        cnt_d;
   logic [BEAT_WIDTH-1:0]   line_q [BEATS];
   logic [BEAT_WIDTH-1:0]   line_d [BEATS];
   logic [LINE_WIDTH-1:0]   ch_rdata_q [NUM_CH];
   logic [LINE_WIDTH-1:0]   ch_rdata_d [NUM_CH];
   logic [NUM_CH-1:0]       ch_resp_q,    ch_resp_d;
   logic                    dram_read_q,  dram_read_d;
   logic                    dram_write_q, dram_write_d;
   logic [BEAT_WIDTH-1:0]   dram_wdata_q, dram_wdata_d;
   logic                    err_q,        err_d;

   // ------------------------------------------------------------------------
   // Unpack the per-channel buses so they can be indexed by channel number
   // ------------------------------------------------------------------------
   logic [ADDR_WIDTH-1:0]   ch_addr_arr  [NUM_CH];
   logic [LINE_WIDTH-1:0]   ch_wdata_arr [NUM_CH];

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign ch_addr_arr[gi]                       = ch_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign ch_wdata_arr[gi]                      = ch_wdata[gi*LINE_WIDTH +: LINE_WIDTH];
         assign ch_rdata[gi*LINE_WIDTH +: LINE_WIDTH] = ch_rdata_q[gi];
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Round-robin arbitration. The search starts at the channel after the
   // previous grant and takes the first channel with a request.
   // ------------------------------------------------------------------------
   logic [NUM_CH-1:0] req;
   logic              grant_vld;
   logic [CH_W-1:0]   grant_idx;

   assign req = ch_read | ch_write;

   always_comb begin
      int              c;
      logic [CH_W-1:0] cand;
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         c = int'(rr_q) + i;
         if (c >= NUM_CH) begin
            c = c - NUM_CH;
         end
         cand = CH_W'(c);
         if (!grant_vld && req[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
   end

   // Writeback line of the winning channel, split into beats.
   logic [LINE_WIDTH-1:0] gnt_wdata;
   logic [BEAT_WIDTH-1:0] gnt_beat [BEATS];
   logic [LINE_WIDTH-1:0] line_flat;
   logic [LINE_WIDTH-1:0] line_asm;

   assign gnt_wdata = ch_wdata_arr[grant_idx];

   generate
      for (genvar gb = 0; gb < BEATS; gb++) begin : g_beat
         assign gnt_beat[gb]                          = gnt_wdata[gb*BEAT_WIDTH +: BEAT_WIDTH];
         assign line_flat[gb*BEAT_WIDTH +: BEAT_WIDTH] = line_q[gb];
      end
   endgenerate

   // The final beat always fills the top slot. The complete line is formed
   // from the stored beats plus the beat arriving now, so it can be written to
   // ch_rdata in the same cycle.
   assign line_asm = {dram_rdata, line_flat[LINE_WIDTH-BEAT_WIDTH-1:0]};

   // ------------------------------------------------------------------------
   // Next-state and registered-output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      ch_d         = ch_q;
      rr_d         = rr_q;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      line_d       = line_q;
      ch_rdata_d   = ch_rdata_q;
      ch_resp_d    = '0;
      dram_read_d  = dram_read_q;
      dram_write_d = dram_write_q;
      dram_wdata_d = dram_wdata_q;
      err_d        = err_q;

      case (state_q)
         ST_IDLE: begin
            if (grant_vld) begin
               ch_d   = grant_idx;
               rr_d   = grant_idx;
               addr_d = ch_addr_arr[grant_idx] & ALIGN_MASK;
               line_d = gnt_beat;
               cnt_d  = '0;
               // When a channel raises read and write together, the write
               // is served first. The read stays pending and is arbitrated
               // again later.
               if (ch_write[grant_idx]) begin
                  state_d      = ST_WR_DATA;
                  dram_write_d = 1'b1;
                  dram_wdata_d = gnt_beat[0];
               end else begin
                  state_d     = ST_RD_CMD;
                  dram_read_d = 1'b1;
               end
            end
         end

         ST_RD_CMD: begin
            if (dram_ready) begin
               dram_read_d = 1'b0;
               state_d     = ST_RD_DATA;
            end
         end

         ST_RD_DATA: begin
            if (dram_rvalid) begin
               if (dram_raddr == addr_q) begin
                  line_d[cnt_q] = dram_rdata;
                  cnt_d         = cnt_q + CNT_W'(1);
                  if (cnt_q == LAST_BEAT) begin
                     ch_rdata_d[ch_q] = line_asm;
                     ch_resp_d[ch_q]  = 1'b1;
                     state_d          = ST_RESP;
                  end
               end else begin
                  // Beats for another line are dropped and not stored.
                  err_d = 1'b1;
               end
            end
         end

         ST_WR_DATA: begin
            if (dram_ready) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_BEAT) begin
                  dram_write_d    = 1'b0;
                  ch_resp_d[ch_q] = 1'b1;
                  state_d         = ST_RESP;
               end else begin
                  dram_wdata_d = line_q[cnt_d];
               end
            end
         end

         ST_RESP: begin
            // No grant here, so IDLE always lasts at least one cycle.
            cnt_d   = '0;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         ch_q         <= '0;
         rr_q         <= RR_INIT;
         addr_q       <= '0;
         cnt_q        <= '0;
         ch_resp_q    <= '0;
         dram_read_q  <= 1'b0;
         dram_write_q <= 1'b0;
         dram_wdata_q <= '0;
         err_q        <= 1'b0;
         for (int b = 0; b < BEATS; b++) begin
            line_q[b] <= '0;
         end
         for (int i = 0; i < NUM_CH; i++) begin
            ch_rdata_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         ch_q         <= ch_d;
         rr_q         <= rr_d;
         addr_q       <= addr_d;
         cnt_q        <= cnt_d;
         ch_resp_q    <= ch_resp_d;
         dram_read_q  <= dram_read_d;
         dram_write_q <= dram_write_d;
         dram_wdata_q <= dram_wdata_d;
         err_q        <= err_d;
         line_q       <= line_d;
         ch_rdata_q   <= ch_rdata_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs (all registered)
   // ------------------------------------------------------------------------
   assign ch_resp    = ch_resp_q;
   assign dram_addr  = addr_q;
   assign dram_read  = dram_read_q;
   assign dram_write = dram_write_q;
   assign dram_wdata = dram_wdata_q;
   assign err_raddr  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_line_arbiter_adapter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_cache_line_arbiter_adapter
//  Purpose  : Directed self-checking bench for cache_line_arbiter_adapter
//             with NUM_CH=2, 32-bit addresses, 256-bit lines, 64-bit beats.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cache_line_arbiter_adapter;

   localparam int NUM_CH = 2;
   localparam int AW     = 32;
   localparam int LW     = 256;
   localparam int BW     = 64;
   localparam int BEATS  = LW / BW;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NUM_CH*AW-1:0] ch_addr;
   logic [NUM_CH*LW-1:0] ch_wdata;
   logic [NUM_CH-1:0]    ch_read;
   logic [NUM_CH-1:0]    ch_write;
   logic [NUM_CH-1:0]    ch_resp;
   logic [NUM_CH*LW-1:0] ch_rdata;
   logic [AW-1:0]        dram_addr;
   logic                 dram_read;
   logic                 dram_write;
   logic [BW-1:0]        dram_wdata;
   logic                 dram_ready;
   logic [AW-1:0]        dram_raddr;
   logic [BW-1:0]        dram_rdata;
   logic                 dram_rvalid;
   logic                 err_raddr;

   int n_tests = 0;
   int n_fail  = 0;

   cache_line_arbiter_adapter #(
      .NUM_CH    (NUM_CH),
      .ADDR_WIDTH(AW),
      .LINE_WIDTH(LW),
      .BEAT_WIDTH(BW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ch_addr    (ch_addr),
      .ch_wdata   (ch_wdata),
      .ch_read    (ch_read),
      .ch_write   (ch_write),
      .ch_resp    (ch_resp),
      .ch_rdata   (ch_rdata),
      .dram_addr  (dram_addr),
      .dram_read  (dram_read),
      .dram_write (dram_write),
      .dram_wdata (dram_wdata),
      .dram_ready (dram_ready),
      .dram_raddr (dram_raddr),
      .dram_rdata (dram_rdata),
      .dram_rvalid(dram_rvalid),
      .err_raddr  (err_raddr)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 ns after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Beat b of test line k. With k=0 the beats are 0x1111..., 0x2222..., and so on.
   function automatic logic [BW-1:0] beat_val(input int k, input int b);
      return (64'(b + 1) * 64'h1111_1111_1111_1111) + (64'(k) << 40);
   endfunction

   function automatic logic [LW-1:0] line_of(input int k);
      return {beat_val(k, 3), beat_val(k, 2), beat_val(k, 1), beat_val(k, 0)};
   endfunction

   // Waits for the read command, returns BEATS matching beats back to back
   // (optionally preceded by one beat for a wrong address), then checks the
   // response. lat counts edges from entry until the response is visible.
   task automatic read_txn(input string tag, input logic [AW-1:0] exp_addr, input int exp_ch,
                           input int k, input bit bad_first, input logic [NUM_CH-1:0] req_after,
                           output int lat);
      int waited;
      waited = 0;
      lat    = 0;
      while (dram_read !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      if (dram_read !== 1'b1) begin
         n_tests++;
         n_fail++;
         $error("FAIL %s_timeout: observed no dram_read, expected dram_read within 20 cycles", tag);
         return;
      end
      check({tag, "_addr"}, dram_addr, exp_addr);
      check({tag, "_no_wr"}, dram_write, 0);
      tick();
      check({tag, "_cmd_pulse"}, dram_read, 0);
      lat = waited + 1;
      if (bad_first) begin
         dram_rvalid = 1'b1;
         dram_raddr  = 32'h0000_2000;
         dram_rdata  = '1;
         tick();
         lat++;
         check({tag, "_err_set"}, err_raddr, 1);
      end
      for (int b = 0; b < BEATS; b++) begin
         dram_rvalid = 1'b1;
         dram_raddr  = exp_addr;
         dram_rdata  = beat_val(k, b);
         tick();
         lat++;
      end
      dram_rvalid = 1'b0;
      check({tag, "_resp"}, ch_resp, 1 << exp_ch);
      check({tag, "_rdata"}, ch_rdata[exp_ch*LW +: LW], line_of(k));
      ch_read = req_after;
      tick();
      check({tag, "_resp_drop"}, ch_resp, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;

      // ---------------- reset ----------------
      rst         = 1'b1;
      ch_addr     = '0;
      ch_wdata    = '0;
      ch_read     = '0;
      ch_write    = '0;
      dram_ready  = 1'b1;
      dram_raddr  = '0;
      dram_rdata  = '0;
      dram_rvalid = 1'b0;
      tick();
      tick();
      tick();
      check("rst_resp",   ch_resp, 0);
      check("rst_rdata0", ch_rdata[0 +: LW], 0);
      check("rst_rdata1", ch_rdata[LW +: LW], 0);
      check("rst_dread",  dram_read, 0);
      check("rst_dwrite", dram_write, 0);
      check("rst_dwdata", dram_wdata, 0);
      check("rst_daddr",  dram_addr, 0);
      check("rst_err",    err_raddr, 0);
      rst = 1'b0;
      tick();

      // ---------------- single read, ch0 ----------------
      // Request sampled at edge 1. Response is visible after edge 6, i.e. in
      // the seventh cycle when the request cycle is counted as the first.
      ch_addr[0 +: AW] = 32'h0000_1234;
      ch_read          = 2'b01;
      read_txn("rd1", 32'h0000_1220, 0, 0, 1'b0, 2'b00, lat);
      check("rd1_latency", lat, 6);

      // ---------------- write ch1 with back-pressure ----------------
      ch_addr[AW +: AW]  = 32'h0000_4000;
      ch_wdata[LW +: LW] = line_of(8);
      ch_write           = 2'b10;
      tick();                                   // grant
      check("wr_valid0", dram_write, 1);
      check("wr_addr",   dram_addr, 32'h0000_4000);
      check("wr_beat0",  dram_wdata, beat_val(8, 0));
      tick();                                   // D0 accepted
      check("wr_beat1a", dram_wdata, beat_val(8, 1));
      dram_ready = 1'b0;
      tick();
      check("wr_beat1b", dram_wdata, beat_val(8, 1));
      check("wr_valid_stall", dram_write, 1);
      tick();
      check("wr_beat1c", dram_wdata, beat_val(8, 1));
      dram_ready = 1'b1;
      tick();                                   // D1 accepted
      check("wr_beat2", dram_wdata, beat_val(8, 2));
      tick();                                   // D2 accepted
      check("wr_beat3", dram_wdata, beat_val(8, 3));
      check("wr_no_resp_yet", ch_resp, 0);
      tick();                                   // D3 accepted
      check("wr_valid_drop", dram_write, 0);
      check("wr_resp", ch_resp, 2'b10);
      check("wr_rdata0_kept", ch_rdata[0 +: LW], line_of(0));
      check("wr_rdata1_kept", ch_rdata[LW +: LW], 0);
      ch_write = 2'b00;
      tick();
      check("wr_resp_drop", ch_resp, 0);

      // ---------------- round-robin: both channels keep reading ----------------
      ch_addr = {32'h0000_0200, 32'h0000_0100};
      ch_read = 2'b11;
      read_txn("rr1", 32'h0000_0100, 0, 1, 1'b0, 2'b11, lat);
      read_txn("rr2", 32'h0000_0200, 1, 2, 1'b0, 2'b11, lat);
      read_txn("rr3", 32'h0000_0100, 0, 3, 1'b0, 2'b00, lat);
      check("rr_ch1_kept", ch_rdata[LW +: LW], line_of(2));

      // ---------------- mismatched read beat ----------------
      check("err_clear_before", err_raddr, 0);
      ch_addr[0 +: AW] = 32'h0000_1234;
      ch_read          = 2'b01;
      read_txn("err", 32'h0000_1220, 0, 4, 1'b1, 2'b00, lat);
      check("err_latency", lat, 7);
      check("err_sticky", err_raddr, 1);

      // ---------------- read+write on ch0: write first ----------------
      ch_addr[0 +: AW]  = 32'h0000_3000;
      ch_wdata[0 +: LW] = line_of(5);
      ch_read           = 2'b01;
      ch_write          = 2'b01;
      tick();
      check("rw_wr_first",  dram_write, 1);
      check("rw_no_rd_cmd", dram_read, 0);
      check("rw_beat0",     dram_wdata, beat_val(5, 0));
      for (int b = 1; b < BEATS; b++) begin
         tick();
         check("rw_beat", dram_wdata, beat_val(5, b));
      end
      tick();
      check("rw_wr_resp",  ch_resp, 2'b01);
      check("rw_rdata_kept", ch_rdata[0 +: LW], line_of(4));
      ch_write = 2'b00;
      tick();
      check("rw_wr_resp_drop", ch_resp, 0);
      read_txn("rw_rd", 32'h0000_3000, 0, 6, 1'b0, 2'b00, lat);

      // ---------------- reset in the middle of a read ----------------
      ch_addr[AW +: AW] = 32'h0000_5000;
      ch_read           = 2'b10;
      tick();
      check("mid_cmd",  dram_read, 1);
      check("mid_addr", dram_addr, 32'h0000_5000);
      tick();
      for (int b = 0; b < 2; b++) begin
         dram_rvalid = 1'b1;
         dram_raddr  = 32'h0000_5000;
         dram_rdata  = 64'hDEAD_0000_0000_0000 + 64'(b);
         tick();
      end
      dram_rvalid = 1'b0;
      rst         = 1'b1;
      tick();
      check("mid_rst_resp",   ch_resp, 0);
      check("mid_rst_rdata0", ch_rdata[0 +: LW], 0);
      check("mid_rst_rdata1", ch_rdata[LW +: LW], 0);
      check("mid_rst_dread",  dram_read, 0);
      check("mid_rst_dwrite", dram_write, 0);
      check("mid_rst_dwdata", dram_wdata, 0);
      check("mid_rst_daddr",  dram_addr, 0);
      check("mid_rst_err",    err_raddr, 0);
      rst = 1'b0;
      read_txn("post_rst", 32'h0000_5000, 1, 7, 1'b0, 2'b00, lat);
      check("post_rst_latency", lat, 6);
      check("post_rst_ch0", ch_rdata[0 +: LW], 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
